// File: rtl/foobar_multi.sv
// Free-running counter feeding NCH divisor channels; each channel flags multiples
// of its run-time divisor and tallies hits, using per-channel residue counters.
module foobar_multi #(
   parameter int WIDTH = 8,
   parameter int NCH = 2,
   parameter logic [NCH*WIDTH-1:0] DIV_INIT = {8'd5, 8'd3},
   parameter bit SAT = 1'b1,
   localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   clr,
   input  logic                   div_we,
   input  logic [SELW-1:0]        div_sel,
   input  logic [WIDTH-1:0]       div_wdata,
   output logic [WIDTH-1:0]       count,
   output logic [NCH-1:0]         hit,
   output logic                   all_hit,
   output logic                   none_hit,
   output logic [NCH*WIDTH-1:0]   hit_cnt
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] div_q   [NCH];
   logic [WIDTH-1:0] res_q   [NCH];
   logic [WIDTH-1:0] tally_q [NCH];
   logic [WIDTH-1:0] div_eff [NCH];

   // Divisors of 0 and 1 both behave as 1, so the residue never leaves 0.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         div_eff[i] = (div_q[i] < WIDTH'(2)) ? WIDTH'(1) : div_q[i];
         hit[i]     = (res_q[i] == '0);
      end
   end

   always_comb begin
      hit_cnt = '0;
      for (int i = 0; i < NCH; i++) begin
         hit_cnt[i*WIDTH +: WIDTH] = tally_q[i];
      end
   end

   assign count    = count_q;
   assign all_hit  = &hit;
   assign none_hit = ~|hit;

   // A divisor write clears the datapath like clr so residues restart aligned.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
         for (int i = 0; i < NCH; i++) begin
            div_q[i]   <= DIV_INIT[i*WIDTH +: WIDTH];
            res_q[i]   <= '0;
            tally_q[i] <= '0;
         end
      end else if (div_we || clr) begin
         count_q <= '0;
         for (int i = 0; i < NCH; i++) begin
            res_q[i]   <= '0;
            tally_q[i] <= '0;
            if (div_we && (div_sel == SELW'(i))) begin
               div_q[i] <= div_wdata;
            end
         end
      end else if (en) begin
         count_q <= count_q + WIDTH'(1);
         for (int i = 0; i < NCH; i++) begin
            // The count wrap realigns every residue since 0 is a multiple of all divisors.
            if ((res_q[i] == div_eff[i] - WIDTH'(1)) || (count_q == '1)) begin
               res_q[i] <= '0;
            end else begin
               res_q[i] <= res_q[i] + WIDTH'(1);
            end
            if (hit[i] && !(SAT && (tally_q[i] == '1))) begin
               tally_q[i] <= tally_q[i] + WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: doc/foobar_multi.md
Name: foobar_multi

Overview:
- Parametrised successor to the two-channel foo/bar counter block.
- A free-running WIDTH-bit counter drives NCH independent divisor channels. Each channel flags when the count is a multiple of its divisor and keeps a saturating or wrapping hit tally.
- Divisors are run-time programmable through a simple write port. No divider or modulo hardware is used; each channel tracks its residue with its own counter.
- Sits as a stimulus/status generator in the lab designs, driven by the common clk and rst.

Parameters:
- WIDTH, 8: bit width of the count, the divisors and each hit counter.
- NCH, 2: number of divisor channels (>=1).
- DIV_INIT, {8'd5, 8'd3}: packed NCH*WIDTH reset divisors; channel i occupies bits [i*WIDTH +: WIDTH].
- SAT, 1: 1 = hit counters saturate at 2^WIDTH-1; 0 = hit counters wrap to 0.

Ports:
- clk, input, 1: clock, rising edge active.
- rst, input, 1: asynchronous active-low reset.
- en, input, 1: count enable.
- clr, input, 1: synchronous clear of count, residues and hit counters.
- div_we, input, 1: divisor write strobe.
- div_sel, input, $clog2(NCH) (min 1): channel selected for the write.
- div_wdata, input, WIDTH: new divisor value.
- count, output, WIDTH: current count.
- hit, output, NCH: hit[i]=1 when count % div[i] == 0 (generalises foo/bar).
- all_hit, output, 1: AND of hit.
- none_hit, output, 1: NOR of hit.
- hit_cnt, output, NCH*WIDTH: per-channel hit tallies, packed like DIV_INIT.

Behaviour:
- Reset (rst=0, asynchronous):
  - count=0, all residues=0, all hit_cnt=0.
  - div[i]=DIV_INIT[i].
  - Therefore hit=all ones, all_hit=1, none_hit=0 immediately, without waiting for a clock edge.
- State per channel: div[i] register, residue r[i] (WIDTH bits), hit_cnt[i].
- Combinational outputs: hit[i] = (r[i]==0); all_hit and none_hit are derived from hit.
- Effective divisor: a div value of 0 or 1 is treated as 1, so hit[i] is constantly 1.
- Clocked update priority, highest first:
  1. div_we=1: div[div_sel] <= div_wdata (out-of-range div_sel is ignored). Count, all residues and all hit_cnt clear to 0, exactly as clr does. en is ignored this cycle.
  2. clr=1: count, residues and hit_cnt clear to 0. Divisors hold. en is ignored.
  3. en=1:
     - hit_cnt[i] increments if hit[i] is 1 at this edge (it tallies the count value being left).
     - Hit-counter boundary: SAT=1 holds at 2^WIDTH-1; SAT=0 wraps to 0.
     - count <= count+1, wrapping 2^WIDTH-1 -> 0.
     - r[i] <= 0 if r[i]==div_eff[i]-1 or count==2^WIDTH-1 (wrap re-aligns the residue); otherwise r[i]+1.
  4. en=0: all state holds.
- Latency:
  - hit and count change in the same cycle after the enabling edge.
  - hit_cnt reflects a hit one edge after the hit was visible.
- Invariant: hit[i] equals (count % div_eff[i] == 0) on every cycle, including immediately after a wrap.
- Reset asserted mid-operation overrides any pending write or clear. After rst release, the first enabled edge moves count 0 -> 1.

Test Plan:
1. Count and hits: defaults, release rst, en=1 for 16 edges.
   - count steps 0..15.
   - hit[0] high at counts 0,3,6,9,12,15.
   - hit[1] high at counts 0,5,10,15.
   - all_hit high at 0 and 15; none_hit high at 1,2,4,7,8,11,13,14.
   - Then hit_cnt = {4, 6}.
2. Wrap: en=1 for 256 edges from reset.
   - At count 255: hit=2'b11.
   - Next edge: count=0, hit=2'b11.
   - hit_cnt = {52, 86}.
   - Edge 257: count=1, hit=2'b00.
3. Saturation: WIDTH=4, NCH=1, DIV_INIT=1.
   - SAT=1: after 20 enabled edges hit_cnt=15 and holds.
   - SAT=0: after 16 enabled edges hit_cnt=0, after 20 edges hit_cnt=4.
4. Divisor write mid-run: at count 7, pulse div_we with div_sel=1, div_wdata=4, en=1.
   - Next cycle count=0 and hit_cnt all 0.
   - Then hit[1] is high at counts 0,4,8; hit[0] still follows divisor 3.
   - Writing 0 to channel 0 makes hit[0] constantly 1.
5. Clear vs write priority: assert clr and div_we on the same edge with en=1.
   - Divisor is loaded; count=0; hit_cnt=0.
   - With en=0 and no clr/div_we for 10 edges, count, hit and hit_cnt are unchanged.
6. Async reset mid-run: drop rst between edges at count 42 after divisor writes.
   - count=0, hit all 1, hit_cnt=0 and divisors back to 3/5 before the next edge.
   - After release, en for 5 edges gives count=5, hit={1,0}.
